kitt_scanner: RTL and testbench

KITT_SCANNER -- requirements
Module: kitt_scanner

---
 rtl/kitt_pkg.sv | 19 +
 rtl/kitt_tick_gen.sv | 38 +++
 rtl/kitt_scanner.sv | 144 ++++++++++++++
 tb/tb_kitt_scanner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/kitt_pkg.sv
// Shared definitions for the KITT scanner: mode and direction encodings
// plus the PWM counter width used by the optional tail (KITT_TAIL_EN).
package kitt_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE    = 2'b00,
    MODE_WRAP_UP   = 2'b01,
    MODE_WRAP_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int PWM_W = 8;

endpackage

// File: rtl/kitt_tick_gen.sv
// Step-period generator: counts BASE>>SPEED cycles while enabled and
// raises i_tick-consumers' tick in the terminal-count cycle.
module kitt_tick_gen
  import kitt_pkg::*;
#(
  parameter int BASE = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_speed,
  output logic       o_tick
);

  localparam int CW = ($clog2(BASE + 1) < 1) ? 1 : $clog2(BASE + 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_term;
  logic [31:0]   w_period;

  // A shifted-away period still has to tick, so it never drops below one cycle.
  always_comb begin
    w_period = 32'(BASE) >> i_speed;
    if (w_period == 32'd0) w_period = 32'd1;
    w_term = CW'(w_period - 32'd1);
  end

  assign o_tick = i_en && (r_count >= w_term);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tick ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/kitt_scanner.sv
// KITT-style LED scanner. Define KITT_TAIL_EN to add a PWM-faded tail of
// TAIL_LEN previous head positions; otherwise LED_OUT is one-hot at POS.
module kitt_scanner
  import kitt_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int STEP_MS  = 200,
  parameter int N_LEDS   = 8,
  parameter int TAIL_LEN = 3
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic [1:0]                MODE,
  input  logic [1:0]                SPEED,
  output logic [N_LEDS-1:0]         LED_OUT,
  output logic [$clog2(N_LEDS)-1:0] POS,
  output logic                      STEP
);

  localparam int BASE = (CLK_FREQ / 1000) * STEP_MS;
  localparam int PW   = $clog2(N_LEDS);
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

  logic              w_tick;
  logic [PW-1:0]     r_pos;
  dir_e              r_dir;
  logic [PW-1:0]     w_nextPos;
  dir_e              w_nextDir;
  mode_e             w_mode;
  logic [N_LEDS-1:0] w_led;

  kitt_tick_gen #(.BASE(BASE)) u_tick (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_en    (EN),
    .i_speed (SPEED),
    .o_tick  (w_tick)
  );

  assign w_mode = mode_e'(MODE);

  // Mode is only looked at on a tick; bounce inherits whatever dir is current.
  always_comb begin
    w_nextPos = r_pos;
    w_nextDir = r_dir;
    if (w_tick) begin
      case (w_mode)
        MODE_BOUNCE: begin
          if (r_dir == DIR_UP) begin
            if (r_pos == LAST) begin
              w_nextDir = DIR_DOWN;
              w_nextPos = r_pos - PW'(1);
            end else begin
              w_nextPos = r_pos + PW'(1);
            end
          end else begin
            if (r_pos == '0) begin
              w_nextDir = DIR_UP;
              w_nextPos = PW'(1);
            end else begin
              w_nextPos = r_pos - PW'(1);
            end
          end
        end
        MODE_WRAP_UP: begin
          w_nextDir = DIR_UP;
          w_nextPos = (r_pos == LAST) ? '0 : r_pos + PW'(1);
        end
        MODE_WRAP_DOWN: begin
          w_nextDir = DIR_DOWN;
          w_nextPos = (r_pos == '0) ? LAST : r_pos - PW'(1);
        end
        default: begin
          w_nextPos = r_pos;
          w_nextDir = r_dir;
        end
      endcase
    end
  end

`ifdef KITT_TAIL_EN
  logic [PW-1:0]       r_hist     [TAIL_LEN];
  logic [TAIL_LEN-1:0] r_histVld;
  logic [PWM_W-1:0]    r_pwm;
  logic [PW-1:0]       w_nextHist [TAIL_LEN];
  logic [TAIL_LEN-1:0] w_nextVld;

  // History only shifts when the head actually moves, so hold keeps it intact.
  always_comb begin
    w_nextHist = r_hist;
    w_nextVld  = r_histVld;
    if (w_nextPos != r_pos) begin
      for (int k = TAIL_LEN - 1; k > 0; k--) begin
        w_nextHist[k] = r_hist[k-1];
        w_nextVld[k]  = r_histVld[k-1];
      end
      w_nextHist[0] = r_pos;
      w_nextVld[0]  = 1'b1;
    end
  end

  always_comb begin
    w_led = '0;
    for (int k = 0; k < TAIL_LEN; k++) begin
      if (w_nextVld[k] && ({1'b0, r_pwm} < (PWM_W + 1)'((1 << PWM_W) >> (k + 1)))) begin
        w_led[w_nextHist[k]] = 1'b1;
      end
    end
    w_led[w_nextPos] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pwm     <= '0;
      r_histVld <= '0;
      r_hist    <= '{default: '0};
    end else begin
      r_pwm     <= r_pwm + PWM_W'(1);
      r_hist    <= w_nextHist;
      r_histVld <= w_nextVld;
    end
  end
`else
  always_comb w_led = N_LEDS'(1) << w_nextPos;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pos   <= '0;
      r_dir   <= DIR_UP;
      LED_OUT <= N_LEDS'(1);
      STEP    <= 1'b0;
    end else begin
      r_pos   <= w_nextPos;
      r_dir   <= w_nextDir;
      LED_OUT <= w_led;
      STEP    <= w_tick;
    end
  end

  assign POS = r_pos;

endmodule

// File: tb/tb_kitt_scanner.sv
// Scoreboard bench for kitt_scanner (BASE=4, N_LEDS=8); the tail duty
// measurement is compiled in only when KITT_TAIL_EN is defined.
module tb_kitt_scanner;

  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         EN = 1'b0;
  logic [1:0]   MODE = 2'b00;
  logic [1:0]   SPEED = 2'b00;
  logic [N-1:0] LED_OUT;
  logic [2:0]   POS;
  logic         STEP;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;

  int mCnt = 0;
  int mPos = 0;
  bit mUp = 1'b1;

  typedef struct {
    int edgeNo;
    int pos;
  } exp_t;
  exp_t expQ[$];

  kitt_scanner #(.CLK_FREQ(1000), .STEP_MS(4), .N_LEDS(N), .TAIL_LEN(3)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .EN      (EN),
    .MODE    (MODE),
    .SPEED   (SPEED),
    .LED_OUT (LED_OUT),
    .POS     (POS),
    .STEP    (STEP)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one step of the scan sequence, straight from the mode rules.
  function automatic void advance(input int mode);
    case (mode)
      0: begin
        if (mUp) begin
          if (mPos == N - 1) begin mUp = 1'b0; mPos = N - 2; end
          else mPos = mPos + 1;
        end else begin
          if (mPos == 0) begin mUp = 1'b1; mPos = 1; end
          else mPos = mPos - 1;
        end
      end
      1: begin mUp = 1'b1; mPos = (mPos + 1) % N; end
      2: begin mUp = 1'b0; mPos = (mPos + N - 1) % N; end
      default: ;
    endcase
  endfunction

  // Drive one cycle of inputs, predict the coming edge, then let it happen.
  task automatic applyStimulus(input bit rstN, input bit en, input int mode, input int speed);
    int period;
    RST_N = rstN;
    EN    = en;
    MODE  = 2'(mode);
    SPEED = 2'(speed);
    period = 4 >> speed;
    if (period == 0) period = 1;
    if (!rstN) begin
      mCnt = 0; mPos = 0; mUp = 1'b1;
    end else if (en) begin
      if (mCnt >= period - 1) begin
        mCnt = 0;
        advance(mode);
        expQ.push_back('{edgeNo: edgeCount + 1, pos: mPos});
      end else begin
        mCnt = mCnt + 1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every STEP pulse consumes the oldest prediction.
  always @(negedge CLK) begin
    if (STEP === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected STEP", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("step edge", edgeCount, e.edgeNo);
        checkOutput("step pos", int'(POS), e.pos);
`ifdef KITT_TAIL_EN
        checkOutput("step head lit", int'(LED_OUT[POS]), 1);
`else
        checkOutput("step led", int'(LED_OUT), 1 << e.pos);
`endif
      end
    end
`ifndef KITT_TAIL_EN
    if (edgeCount > 0) checkOutput("onehot", int'(LED_OUT), 1 << POS);
`endif
  end

  initial begin
    int guard;
    int curMode;
    int curSpeed;

    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("reset pos", int'(POS), 0);
    checkOutput("reset led", int'(LED_OUT), 1);
    checkOutput("reset step", int'(STEP), 0);

`ifdef KITT_TAIL_EN
    begin
      int on5, on4, on3, on2;
      on5 = 0; on4 = 0; on3 = 0; on2 = 0;
      guard = 0;
      while (!(mPos == 5 && mUp) && guard < 100) begin
        applyStimulus(1, 1, 0, 0);
        guard++;
      end
      checkOutput("tail reach head5", mPos, 5);
      for (int i = 0; i < 256; i++) begin
        applyStimulus(1, 1, 3, 0);
        on5 += int'(LED_OUT[5]);
        on4 += int'(LED_OUT[4]);
        on3 += int'(LED_OUT[3]);
        on2 += int'(LED_OUT[2]);
      end
      checkOutput("tail head duty", on5, 256);
      checkOutput("tail1 duty", on4, 128);
      checkOutput("tail2 duty", on3, 64);
      checkOutput("tail3 duty", on2, 32);
      applyStimulus(0, 1, 0, 0);
    end
`endif

    // Full bounce sweep 0..7..0,1
    for (int i = 0; i < 4 * 15; i++) applyStimulus(1, 1, 0, 0);
    checkOutput("bounce end pos", int'(POS), 1);

    // Wrap-up across 7->0, wrap-down across 0->7, then hold
    for (int i = 0; i < 4 * 9; i++) applyStimulus(1, 1, 1, 0);
    for (int i = 0; i < 4 * 10; i++) applyStimulus(1, 1, 2, 0);
    for (int i = 0; i < 4 * 3; i++) applyStimulus(1, 1, 3, 0);

    // Fast speed, then a speed change landing on the terminal count
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 2);
    guard = 0;
    while (mCnt != 3 && guard < 10) begin applyStimulus(1, 1, 0, 0); guard++; end
    checkOutput("cnt reaches 3", mCnt, 3);
    applyStimulus(1, 1, 0, 2);
    applyStimulus(1, 1, 0, 0);

    // Freeze mid-period and resume
    guard = 0;
    while (mCnt != 2 && guard < 10) begin applyStimulus(1, 1, 0, 0); guard++; end
    checkOutput("cnt reaches 2", mCnt, 2);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);

    // Reset while heading down at 5
    guard = 0;
    while (!(mPos == 5 && !mUp) && guard < 200) begin applyStimulus(1, 1, 0, 0); guard++; end
    checkOutput("reach pos5 down", mPos * 2 + int'(mUp), 10);
    applyStimulus(0, 1, 0, 0);
    checkOutput("midreset pos", int'(POS), 0);
    checkOutput("midreset led", int'(LED_OUT), 1);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0);

    // Random stimulus
    curMode = 0;
    curSpeed = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) curMode = int'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) curSpeed = int'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 7) != 0, curMode, curSpeed);
    end

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
